// File: rtl/dma_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dma_pkg: shared types and default memory depths for the AES burst DMA engine
// Rev 1.0
// ----------------------------------------------------------------------------
package dma_pkg;

  typedef enum logic [1:0] {
    MODE_LOAD  = 2'd0,
    MODE_STORE = 2'd1,
    MODE_COPY  = 2'd2
  } dma_mode_t;

  typedef enum logic {
    MEM_KEY   = 1'b0,
    MEM_STATE = 1'b1
  } dma_mem_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_CAPTURE   = 3'd2,
    ST_OUT       = 3'd3,
    ST_WRITE     = 3'd4,
    ST_STREAM_IN = 3'd5,
    ST_DONE      = 3'd6
  } dma_state_t;

  localparam int DEFAULT_KEY_DEPTH   = 11;
  localparam int DEFAULT_STATE_DEPTH = 16;

  // A zero-length burst touches nothing, so it is always in range.
  function automatic logic range_ok(input int addr, input int len, input int depth);
    return (len == 0) || (addr + len <= depth);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dma_burst_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dma_burst_ctrl_if: descriptor, stream and memory-port bundle of the DMA engine
// Rev 1.0
// ----------------------------------------------------------------------------
interface dma_burst_ctrl_if #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 4,
  parameter int LEN_W      = 5
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_mode;
  logic                  cmd_src_sel;
  logic                  cmd_dst_sel;
  logic [ADDR_WIDTH-1:0] cmd_src_addr;
  logic [ADDR_WIDTH-1:0] cmd_dst_addr;
  logic [LEN_W-1:0]      cmd_len;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;

  logic [ADDR_WIDTH-1:0] key_addr;
  logic                  key_we;
  logic [DATA_WIDTH-1:0] key_wdata;
  logic [DATA_WIDTH-1:0] key_rdata;

  logic [ADDR_WIDTH-1:0] st_addr;
  logic                  st_we;
  logic [DATA_WIDTH-1:0] st_wdata;
  logic [DATA_WIDTH-1:0] st_rdata;

  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    input  cmd_valid, cmd_mode, cmd_src_sel, cmd_dst_sel, cmd_src_addr, cmd_dst_addr, cmd_len,
    output cmd_ready,
    output out_valid, out_data,
    input  out_ready,
    input  in_valid, in_data,
    output in_ready,
    output key_addr, key_we, key_wdata,
    input  key_rdata,
    output st_addr, st_we, st_wdata,
    input  st_rdata,
    output busy, done, err
  );

  modport slave (
    output cmd_valid, cmd_mode, cmd_src_sel, cmd_dst_sel, cmd_src_addr, cmd_dst_addr, cmd_len,
    input  cmd_ready,
    input  out_valid, out_data,
    output out_ready,
    output in_valid, in_data,
    input  in_ready,
    input  key_addr, key_we, key_wdata,
    output key_rdata,
    input  st_addr, st_we, st_wdata,
    output st_rdata,
    input  busy, done, err
  );
endinterface
`default_nettype wire

// File: rtl/dma_addr_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dma_addr_gen: burst address counter with remaining-word down-counter
// Rev 1.0
// ----------------------------------------------------------------------------
module dma_addr_gen #(
  parameter int ADDR_WIDTH = 4,
  parameter int LEN_W      = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [LEN_W-1:0]      len,
  input  logic                  step,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last
);
  logic [LEN_W-1:0] remaining;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= '0;
      remaining <= '0;
    end else if (load) begin
      addr      <= base;
      remaining <= len;
    end else if (step) begin
      addr      <= addr + ADDR_WIDTH'(1);
      remaining <= remaining - LEN_W'(1);
    end
  end

  assign last = (remaining == LEN_W'(1));
endmodule
`default_nettype wire

// File: rtl/dma_burst_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dma_burst_ctrl: burst DMA moving 128-bit blocks between key memory, state RAM and streams
// Rev 1.0
// ----------------------------------------------------------------------------
module dma_burst_ctrl
  import dma_pkg::*;
#(
  parameter int DATA_WIDTH  = 128,
  parameter int ADDR_WIDTH  = 4,
  parameter int KEY_DEPTH   = DEFAULT_KEY_DEPTH,
  parameter int STATE_DEPTH = DEFAULT_STATE_DEPTH,
  parameter int MAX_BURST   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  dma_burst_ctrl_if.master bus
);
  localparam int LEN_W = $clog2(MAX_BURST + 1);

  dma_state_t            state, state_nxt;
  dma_mode_t             mode_q;
  dma_mem_t              src_sel_q, dst_sel_q;
  logic                  err_q;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q, cap_q, src_rdata;
  logic                  accept, cmd_bad;
  logic [ADDR_WIDTH-1:0] src_addr, dst_addr;
  logic                  src_last, dst_last, src_step, dst_step;
  logic                  mem_active, mem_we;
  dma_mem_t              mem_sel;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  in_ready;

  assign accept = (state == ST_IDLE) && bus.cmd_valid;

  always_comb begin
    cmd_bad = 1'b0;
    if (bus.cmd_mode == 2'd3) begin
      cmd_bad = 1'b1;
    end else if (int'(bus.cmd_len) > MAX_BURST) begin
      cmd_bad = 1'b1;
    end else begin
      if (bus.cmd_mode != MODE_STORE &&
          !range_ok(int'(bus.cmd_src_addr), int'(bus.cmd_len),
                    bus.cmd_src_sel ? STATE_DEPTH : KEY_DEPTH))
        cmd_bad = 1'b1;
      if (bus.cmd_mode != MODE_LOAD &&
          !range_ok(int'(bus.cmd_dst_addr), int'(bus.cmd_len),
                    bus.cmd_dst_sel ? STATE_DEPTH : KEY_DEPTH))
        cmd_bad = 1'b1;
    end
  end

  assign src_step = (state == ST_OUT && bus.out_ready) || (state == ST_WRITE);
  assign dst_step = (state == ST_WRITE) || (state == ST_STREAM_IN && bus.in_valid);

  dma_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .LEN_W(LEN_W)) u_src_gen (
    .clk(clk), .rst_n(rst_n), .load(accept), .base(bus.cmd_src_addr),
    .len(bus.cmd_len), .step(src_step), .addr(src_addr), .last(src_last)
  );

  dma_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .LEN_W(LEN_W)) u_dst_gen (
    .clk(clk), .rst_n(rst_n), .load(accept), .base(bus.cmd_dst_addr),
    .len(bus.cmd_len), .step(dst_step), .addr(dst_addr), .last(dst_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          if (cmd_bad || bus.cmd_len == '0)    state_nxt = ST_DONE;
          else if (bus.cmd_mode == MODE_STORE) state_nxt = ST_STREAM_IN;
          else                                 state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE:     state_nxt = ST_CAPTURE;
      ST_CAPTURE:   state_nxt = (mode_q == MODE_LOAD) ? ST_OUT : ST_WRITE;
      ST_OUT:       if (bus.out_ready) state_nxt = src_last ? ST_DONE : ST_ISSUE;
      ST_WRITE:     state_nxt = dst_last ? ST_DONE : ST_ISSUE;
      ST_STREAM_IN: if (bus.in_valid && dst_last) state_nxt = ST_DONE;
      ST_DONE:      state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  assign src_rdata = (src_sel_q == MEM_STATE) ? bus.st_rdata : bus.key_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= MODE_LOAD;
      src_sel_q   <= MEM_KEY;
      dst_sel_q   <= MEM_KEY;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      cap_q       <= '0;
    end else begin
      if (accept) begin
        mode_q    <= (bus.cmd_mode == 2'd1) ? MODE_STORE :
                     (bus.cmd_mode == 2'd2) ? MODE_COPY : MODE_LOAD;
        src_sel_q <= dma_mem_t'(bus.cmd_src_sel);
        dst_sel_q <= dma_mem_t'(bus.cmd_dst_sel);
        err_q     <= cmd_bad;
      end else if (state == ST_DONE) begin
        err_q <= 1'b0;
      end

      if (state == ST_CAPTURE) begin
        cap_q <= src_rdata;
        if (mode_q == MODE_LOAD) begin
          out_data_q  <= src_rdata;
          out_valid_q <= 1'b1;
        end
      end else if (state == ST_OUT && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // One shared port request, steered to whichever memory it targets.
  always_comb begin
    mem_active = 1'b0;
    mem_sel    = src_sel_q;
    mem_addr   = '0;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    in_ready   = 1'b0;
    case (state)
      ST_ISSUE: begin
        mem_active = 1'b1;
        mem_sel    = src_sel_q;
        mem_addr   = src_addr;
      end
      ST_WRITE: begin
        mem_active = 1'b1;
        mem_sel    = dst_sel_q;
        mem_addr   = dst_addr;
        mem_we     = 1'b1;
        mem_wdata  = cap_q;
      end
      ST_STREAM_IN: begin
        in_ready   = 1'b1;
        mem_active = 1'b1;
        mem_sel    = dst_sel_q;
        mem_addr   = dst_addr;
        mem_we     = bus.in_valid;
        mem_wdata  = bus.in_data;
      end
      default: ;
    endcase
  end

  assign bus.key_addr  = (mem_active && mem_sel == MEM_KEY) ? mem_addr : '0;
  assign bus.key_we    = mem_active && (mem_sel == MEM_KEY) && mem_we;
  assign bus.key_wdata = (mem_active && mem_sel == MEM_KEY) ? mem_wdata : '0;
  assign bus.st_addr   = (mem_active && mem_sel == MEM_STATE) ? mem_addr : '0;
  assign bus.st_we     = mem_active && (mem_sel == MEM_STATE) && mem_we;
  assign bus.st_wdata  = (mem_active && mem_sel == MEM_STATE) ? mem_wdata : '0;

  assign bus.in_ready  = in_ready;
  assign bus.cmd_ready = (state == ST_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = (state != ST_IDLE);
  assign bus.done      = (state == ST_DONE);
  assign bus.err       = err_q;
endmodule
`default_nettype wire

// File: doc/dma_burst_ctrl.md
Name: dma_burst_ctrl

Overview:
- Parametrised burst DMA engine moving 128-bit AES blocks between the round-key memory, the state RAM, and the round datapath.
- Accepts one descriptor at a time: source/destination memory, start addresses and burst length.
- Three modes: LOAD (memory to output stream), STORE (input stream to memory), COPY (memory to memory).
- Valid/ready backpressure on both streams; range errors are rejected before any memory access. Memories sit outside the block on two synchronous-read ports.

Parameters:
- DATA_WIDTH, 128, word width of memories and streams.
- ADDR_WIDTH, 4, address width of both memory ports.
- KEY_DEPTH, 11, number of valid round-key memory words.
- STATE_DEPTH, 16, number of valid state RAM words.
- MAX_BURST, 16, largest legal burst length. LEN_W = $clog2(MAX_BURST+1).

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- cmd_valid / cmd_ready, in / out, 1 / 1, descriptor handshake.
- cmd_mode, in, 2, descriptor mode: 0 LOAD, 1 STORE, 2 COPY, 3 reserved.
- cmd_src_sel / cmd_dst_sel, in, 1 / 1, memory select: 0 key memory, 1 state RAM.
- cmd_src_addr / cmd_dst_addr, in, ADDR_WIDTH each, start addresses.
- cmd_len, in, LEN_W, burst length in words.
- out_valid / out_ready / out_data, out / in / out, 1 / 1 / DATA_WIDTH, LOAD output stream.
- in_valid / in_ready / in_data, in / out / in, 1 / 1 / DATA_WIDTH, STORE input stream.
- key_addr / key_we / key_wdata, out, ADDR_WIDTH / 1 / DATA_WIDTH, key memory port.
- key_rdata, in, DATA_WIDTH, key memory read data (1-cycle read latency).
- st_addr / st_we / st_wdata, out, ADDR_WIDTH / 1 / DATA_WIDTH, state RAM port.
- st_rdata, in, DATA_WIDTH, state RAM read data (1-cycle read latency).
- busy, out, 1, high whenever state != IDLE.
- done / err, out, 1 / 1, completion pulse and error flag.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; out_valid=0, out_data=0, done=0, err=0, busy=0, key_we=st_we=0, all counters 0. cmd_ready=1 once reset is released.
- Reset mid-burst aborts immediately. Words already written stay in memory; no done pulse is issued.
- FSM states: IDLE, ISSUE, CAPTURE, OUT, WRITE, STREAM_IN, DONE.
- cmd_ready = (state==IDLE). The descriptor is latched on cmd_valid&cmd_ready.
- Descriptor validation at accept:
  - Error conditions: mode==3; cmd_len>MAX_BURST; addr+len-1 beyond the selected depth, for the source (LOAD/COPY) or destination (STORE/COPY).
  - On error: go to DONE with err latched; zero memory accesses.
  - cmd_len==0: go straight to DONE, no error.
- Memory-port gating: port outputs are combinational from FSM and address counters. Only the selected memory's addr toggles; the other holds 0 with we=0.
- LOAD, per word:
  - ISSUE drives source addr.
  - CAPTURE: rdata is valid; at the edge, out_data<=rdata and out_valid<=1.
  - OUT holds out_data and out_valid stable until out_ready.
  - On the out_valid&out_ready edge: out_valid<=0, source addr+1, remaining-1; next state is ISSUE, or DONE if remaining was 1.
  - First out_valid appears 3 cycles after the accept edge.
- STORE: STREAM_IN with in_ready=1. Each in_valid cycle asserts dst we with wdata=in_data and addr=current, then increments. After the last word, go to DONE.
- COPY, per word: ISSUE -> CAPTURE (rdata registered internally) -> WRITE (dst we=1, wdata=captured word), then increment both addresses.
  - Words are processed in strictly ascending order.
  - src_sel==dst_sel is legal; overlapping ranges yield forward-copy semantics.
- DONE lasts exactly 1 cycle: done=1, err=1 if latched; err is cleared on exit. Then IDLE.
- Addresses never wrap: range checking guarantees in-bounds access.

Decomposition:
- dma_pkg holds:
  - dma_mode_t enum: MODE_LOAD=0, MODE_STORE=1, MODE_COPY=2.
  - dma_mem_t enum: MEM_KEY=0, MEM_STATE=1.
  - dma_state_t FSM enum.
  - KEY_DEPTH and STATE_DEPTH default constants.
- One sub-module, dma_addr_gen: base load, increment, remaining-count down-counter and last-word flag. Instantiated twice, for source and destination.

Test Plan:
- Reset mid-LOAD (rst_n low during OUT) -> out_valid=0, busy=0, done never pulses; a new descriptor is accepted next cycle.
- LOAD key memory addr 0, len 11, out_ready=1 -> 11 words in order matching key words 0..10; first out_valid 3 cycles after accept; single done pulse, err=0.
- LOAD state RAM addr 4, len 3, out_ready toggled 0/1 every 2 cycles -> out_data stable while stalled, words 4,5,6 delivered exactly once.
- STORE state RAM addr 14, len 2, in_valid gapped -> writes 14 and 15 only on in_valid cycles, then done. Same with len 3 -> err=1, done=1, zero st_we pulses.
- COPY key addr 2 -> state addr 8, len 4 -> state[8..11] equals key[2..5]; key_we never asserted.
- Descriptor mode=3 or len=17 -> done and err high for exactly 1 cycle, no memory access. len=0 -> done with err=0.
